// File: rtl/vdcm_pkg.sv
// vdcm_pkg: shared types and constants for the substream demultiplexer.
//   MUX_WORD_W   : width of one rate-buffer mux word
//   NUM_SSM_DEF  : default number of substreams
//   demux_state_t: demux control states IDLE / PRIME / RUN
//   ssm_idx_t    : substream index for the default substream count
package vdcm_pkg;

  localparam int MUX_WORD_W  = 128;
  localparam int NUM_SSM_DEF = 4;
  localparam int SSM_IDX_W   = $clog2(NUM_SSM_DEF);

  typedef logic [MUX_WORD_W-1:0] mux_word_t;
  typedef logic [SSM_IDX_W-1:0]  ssm_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } demux_state_t;

endpackage

// File: rtl/ssm_demux_if.sv
// ssm_demux_if: valid/ready mux-word stream from the rate buffer.
//   in_data  : 128-bit mux word
//   in_valid : in_data valid
//   in_ready : word accepted when in_valid & in_ready
//   master   : rate-buffer side, slave: demux side
interface ssm_demux_if;

  vdcm_pkg::mux_word_t in_data;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ssm_word_fifo.sv
// ssm_word_fifo: first-word-fall-through FIFO of mux words for one substream.
//   clk, rstn : clock, async active-low reset
//   i_push    : write i_wdata (dropped when full and not popping)
//   i_pop     : drop the head word (ignored when empty)
//   o_empty   : no words stored
//   o_full    : DEPTH words stored
//   o_head    : current head word, zero when empty
// DEPTH must be a power of two, at least 2; pointers carry an extra wrap bit.
module ssm_word_fifo
  import vdcm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      i_push,
  input  mux_word_t i_wdata,
  input  logic      i_pop,
  output logic      o_empty,
  output logic      o_full,
  output mux_word_t o_head
);

  localparam int AW = $clog2(DEPTH);

  mux_word_t     r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot being written, so full+pop may push.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = o_empty ? {MUX_WORD_W{1'b0}} : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; power-of-two depth lets the wrap bit fall out of the carry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Word storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/ssm_demux.sv
// ssm_demux: substream demultiplexer feeding the per-substream bit parsers.
//   clk, rstn  : clock, async active-low reset
//   start_dec  : level, starts priming from IDLE
//   bus        : mux-word stream (in_data / in_valid / in_ready), slave side
//   ssm_rd_en  : per-substream pop from the parsers
//   ssm_data   : FWFT head word per substream, zero when empty
//   ssm_empty  : per-substream FIFO empty flags
//   ssm_ready  : priming complete
//   demux_err  : sticky error flag
// Optional macro SSM_DEMUX_ERRCHK_EN builds the error checks; without it
// demux_err is tied low.
// Priming sends word n to substream n mod NUM_SSM. Afterwards every pop
// enqueues its substream index, and each accepted word goes to the substream
// at the head of that request queue, so occupancy + pending requests stays
// INIT_WORDS per substream.
module ssm_demux
  import vdcm_pkg::*;
#(
  parameter int NUM_SSM    = NUM_SSM_DEF,
  parameter int INIT_WORDS = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_dec,
  ssm_demux_if.slave         bus,
  input  logic [NUM_SSM-1:0] ssm_rd_en,
  output mux_word_t          ssm_data [NUM_SSM],
  output logic [NUM_SSM-1:0] ssm_empty,
  output logic               ssm_ready,
  output logic               demux_err
);

  localparam int QD    = NUM_SSM * INIT_WORDS;
  localparam int QAW   = $clog2(QD);
  localparam int IDX_W = $clog2(NUM_SSM);

  typedef logic [IDX_W-1:0] idx_t;
  typedef struct packed {
    logic           wrap;
    logic [QAW-1:0] idx;
  } qptr_t;

  // Queue depth need not be a power of two, so wrap explicitly.
  function automatic qptr_t qinc(input qptr_t p);
    qptr_t r;
    if (p.idx == QAW'(QD - 1)) begin
      r.wrap = ~p.wrap;
      r.idx  = {QAW{1'b0}};
    end else begin
      r.wrap = p.wrap;
      r.idx  = p.idx + QAW'(1);
    end
    return r;
  endfunction

  demux_state_t       r_state;
  logic [QAW-1:0]     r_prime_cnt;
  logic               r_ssm_ready;
  qptr_t              r_q_wr;
  qptr_t              r_q_rd;
  idx_t               r_q [QD];

  logic [NUM_SSM-1:0] w_empty;
  logic [NUM_SSM-1:0] w_full;
  logic [NUM_SSM-1:0] w_pop;
  logic [NUM_SSM-1:0] w_push;
  logic               w_q_empty;
  idx_t               w_q_head;
  idx_t               w_target;
  logic               w_in_ready;
  logic               w_accept;
  qptr_t              w_q_wr_nxt;
  qptr_t              w_slot [NUM_SSM];

  assign w_q_empty = (r_q_wr == r_q_rd);
  assign w_q_head  = r_q[r_q_rd.idx];
  // Parser pops only count once running; pops of empty FIFOs are dropped.
  assign w_pop     = ssm_rd_en & ~w_empty & {NUM_SSM{r_state == RUN}};
  assign w_accept  = bus.in_valid & w_in_ready;

  assign bus.in_ready = w_in_ready;
  assign ssm_empty    = w_empty;
  assign ssm_ready    = r_ssm_ready;

  // Destination substream and acceptance for the word on the bus.
  always_comb begin
    w_target   = {IDX_W{1'b0}};
    w_in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_target   = {IDX_W{1'b0}};
        w_in_ready = 1'b0;
      end
      PRIME: begin
        w_target   = IDX_W'(r_prime_cnt % QAW'(NUM_SSM));
        w_in_ready = ~w_full[w_target];
      end
      RUN: begin
        w_target   = w_q_head;
        // Full cannot occur while the occupancy invariant holds; kept as a guard.
        w_in_ready = ~w_q_empty & ~w_full[w_target];
      end
      default: begin
        w_target   = {IDX_W{1'b0}};
        w_in_ready = 1'b0;
      end
    endcase
  end

  // Per-substream write strobes from the accepted word.
  always_comb begin
    w_push = {NUM_SSM{1'b0}};
    for (int k = 0; k < NUM_SSM; k++) begin
      w_push[k] = w_accept && (w_target == IDX_W'(k));
    end
  end

  // Same-cycle pops get consecutive queue slots in ascending substream order.
  always_comb begin
    qptr_t v_ptr;
    v_ptr = r_q_wr;
    for (int k = 0; k < NUM_SSM; k++) begin
      w_slot[k] = v_ptr;
      if (w_pop[k]) begin
        v_ptr = qinc(v_ptr);
      end else begin
        v_ptr = v_ptr;
      end
    end
    w_q_wr_nxt = v_ptr;
  end

  // Control FSM with prime counter, ready flag and request-queue pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_prime_cnt <= {QAW{1'b0}};
      r_ssm_ready <= 1'b0;
      r_q_wr      <= {1'b0, {QAW{1'b0}}};
      r_q_rd      <= {1'b0, {QAW{1'b0}}};
    end else begin
      case (r_state)
        IDLE: begin
          if (start_dec) begin
            r_state     <= PRIME;
            r_prime_cnt <= {QAW{1'b0}};
          end
        end
        PRIME: begin
          if (w_accept) begin
            if (r_prime_cnt == QAW'(QD - 1)) begin
              r_state     <= RUN;
              r_ssm_ready <= 1'b1;
            end else begin
              r_prime_cnt <= r_prime_cnt + QAW'(1);
            end
          end
        end
        RUN: begin
          r_q_wr <= w_q_wr_nxt;
          if (w_accept) begin
            r_q_rd <= qinc(r_q_rd);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Request-queue storage; validity comes from the pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SSM; k++) begin
      if (w_pop[k]) begin
        r_q[w_slot[k].idx] <= IDX_W'(k);
      end
    end
  end

  for (genvar g = 0; g < NUM_SSM; g++) begin : g_fifo
    ssm_word_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (w_push[g]),
      .i_wdata (bus.in_data),
      .i_pop   (w_pop[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g]),
      .o_head  (ssm_data[g])
    );
  end

`ifdef SSM_DEMUX_ERRCHK_EN
  logic r_err;
  logic w_err_evt;

  assign w_err_evt = (|(ssm_rd_en & w_empty)) |
                     (|(w_push & w_full & ~w_pop)) |
                     ((|ssm_rd_en) & ~r_ssm_ready);

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_err_evt;
    end
  end

  assign demux_err = r_err;
`else
  assign demux_err = 1'b0;
`endif

endmodule

// File: doc/ssm_demux.md
# ssm_demux

Substream demultiplexer sitting directly upstream of the per-substream bit parsers (one parser per SSM). Accepts the serial stream of 128-bit mux words from the rate buffer, primes each substream FIFO with its initial words, then routes each following mux word to the substream whose parser consumed a word earliest. Each SSM's head word is presented first-word-fall-through, so a parser's read enable pops the word it samples in the same cycle.

## Interface
Parameters:
- NUM_SSM, 4, number of substreams/parsers
- INIT_WORDS, 2, mux words pushed to each SSM during priming (1..FIFO_DEPTH)
- FIFO_DEPTH, 4, words per substream FIFO (power of 2)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start_dec  in  1  level; begin priming on first high cycle after idle
- in_data  in  128  mux word from rate buffer
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid & in_ready
- ssm_rd_en  in  NUM_SSM  per-SSM pop (parser codec_data_rd_en)
- ssm_data  out  128 x NUM_SSM (unpacked array)  FIFO head word per SSM, 0 when empty
- ssm_empty  out  NUM_SSM  FIFO empty flags
- ssm_ready  out  1  priming complete; parsers may start
- demux_err  out  1  sticky error (see Configuration)

## Operation
- States: IDLE, PRIME, RUN.
- IDLE: in_ready=0. start_dec=1 -> PRIME, prime counter cleared.
- PRIME: word n (n = 0 .. NUM_SSM*INIT_WORDS-1) routed to SSM n mod NUM_SSM. After last word -> RUN, ssm_ready=1.
- RUN: request queue (depth NUM_SSM*INIT_WORDS) holds SSM indices in pop order. Each ssm_rd_en bit pops that FIFO and enqueues its index. Several pops in one cycle enqueue in ascending SSM index. Accepted in_data goes to SSM at queue head; head dequeued.
- in_ready in RUN = queue non-empty. Invariant: occupancy(k) + pending requests(k) = INIT_WORDS, so FIFOs never overflow.
- start_dec low in PRIME/RUN: no effect. Only rstn returns to IDLE.
- ssm_rd_en on empty FIFO: ignored (no pop, no enqueue). Flagged when error checking is compiled in.
- Reset: state IDLE, FIFOs and queue empty, in_ready=0, ssm_ready=0, ssm_empty=all 1, ssm_data=0, demux_err=0. Reset mid-operation discards all buffered words and pending requests.

## Timing
- Word accepted at edge t: visible on ssm_data, ssm_empty cleared from cycle t+1.
- Pop at edge t: next FIFO word, or 0 with empty, from t+1. Request visible at queue head from t+1, so in_ready can rise at t+1. No same-cycle pop-to-refill bypass.
- Same-cycle pop of SSM k and write to SSM k: both take effect, occupancy unchanged.
- ssm_ready rises the cycle after the last priming word is accepted.
- Pointers wrap modulo FIFO_DEPTH and queue depth. Full and empty are distinguished with an extra wrap bit.

## Configuration
- SSM_DEMUX_ERRCHK_EN defined:
  - demux_err sets on a pop of an empty FIFO.
  - demux_err sets on a write to a full FIFO.
  - demux_err sets on ssm_rd_en!=0 before ssm_ready.
  - demux_err clears only on reset.
- Undefined: demux_err tied 0 and no check logic is built. Functional behaviour is otherwise identical.

## Structure
- Shared package vdcm_pkg:
  - MUX_WORD_W=128
  - default NUM_SSM
  - state enum {IDLE, PRIME, RUN}
  - SSM index typedef, width $clog2(NUM_SSM)
- Sub-module ssm_word_fifo: FWFT FIFO, FIFO_DEPTH x 128, with push, pop, empty, full and head output. Instantiated NUM_SSM times.
- Request queue and FSM live in ssm_demux.

## Test plan
- Prime: start_dec, 8 words W0..W7 -> SSM0 holds W0,W4; SSM1 holds W1,W5; SSM2 holds W2,W6; SSM3 holds W3,W7. ssm_ready=1 the cycle after W7. in_ready=0 afterward.
- Ordered refill: pop SSM2, then SSM0 next cycle; feed W8, W9 -> W8 goes to SSM2 tail, W9 to SSM0 tail. in_ready rises 1 cycle after first pop.
- Simultaneous pops: ssm_rd_en=4'b1010 in one cycle; feed W8, W9 -> W8 to SSM1, W9 to SSM3.
- Backpressure: pops of SSM0 x2, in_valid low 5 cycles then W8, W9 -> both go to SSM0, no loss. in_ready held high throughout the gap.
- Empty pop with SSM_DEMUX_ERRCHK_EN: drain SSM3 by 2 pops, pop again -> demux_err=1 sticky. No extra queue entry, so W8 goes to SSM3 once.
- Reset mid-RUN: rstn low with pending requests -> all outputs at reset values. Re-prime works from W0.
